// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_phy_pkg
// Brief    : Shared symbol constants, scrambler seed, per-symbol pipeline
//            record and LFSR helper functions for the Gen1 scrambler.
// Revision : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    // 8b/10b K-code values as seen on the 8-bit symbol bus
    localparam logic [7:0]  COM       = 8'hBC;   // K28.5
    localparam logic [7:0]  SKP       = 8'h1C;   // K28.0
    localparam logic [7:0]  PAD       = 8'hF7;   // K23.7
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    // One symbol lane of the first pipeline stage: raw symbol plus the
    // keystream byte and the final "apply XOR" decision made for it.
    typedef struct packed {
        logic [7:0] data;
        logic       k;
        logic [7:0] key;
        logic       scramble;
    } sym_stage_t;

    // Eight serial steps of the Galois LFSR x^16+x^5+x^4+x^3+1.
    function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int b = 0; b < 8; b++) begin
            r = {r[14:5], r[4] ^ r[15], r[3] ^ r[15], r[2] ^ r[15], r[1], r[0], r[15]};
        end
        return r;
    endfunction

    // Data bit i is XORed with LFSR bit 15 after i steps, which is the
    // initial bit 15-i, so the keystream byte is the reversed top byte.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_scramble.sv
`default_nettype none
// ============================================================================
// Module   : byte_scramble
// Brief    : Single-symbol scrambler step. Produces the keystream byte for
//            the incoming LFSR state, advances/reseeds the LFSR and tracks
//            the ordered-set bypass window. Chained once per symbol lane.
// Revision : 1.0 - initial release
// ============================================================================
module byte_scramble
    import pcie_phy_pkg::*;
#(
    parameter int OS_LEN = 16,
    parameter int CNT_W  = 5
) (
    input  logic             active,
    input  logic [7:0]       sym,
    input  logic             sym_k,
    input  logic [15:0]      lfsr_in,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             pend_in,
    output logic [15:0]      lfsr_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             pend_out,
    output logic [7:0]       key,
    output logic             bypass
);

    // The symbol right after COM is the first bypassed one; the counter
    // then holds the number of bypassed symbols still to come.
    localparam logic [CNT_W-1:0] c_WIN_RELOAD = CNT_W'(OS_LEN - 2);

    logic w_is_com;
    logic w_is_skp;

    assign w_is_com = sym_k && (sym == COM);
    assign w_is_skp = sym_k && (sym == SKP);
    assign key      = bit_rev8(lfsr_in[15:8]);

    // Next LFSR / window state for this symbol; inactive lanes pass through.
    always_comb begin
        lfsr_out = lfsr_in;
        cnt_out  = cnt_in;
        pend_out = pend_in;
        bypass   = 1'b0;
        if (active) begin
            if (w_is_com) begin
                lfsr_out = LFSR_SEED;
                cnt_out  = '0;
                pend_out = 1'b1;
            end else begin
                if (!w_is_skp) begin
                    lfsr_out = lfsr_step8(lfsr_in);
                end
                if (pend_in) begin
                    // COM followed by SKP is a SKP ordered set: no window.
                    pend_out = 1'b0;
                    if (!w_is_skp) begin
                        bypass  = 1'b1;
                        cnt_out = c_WIN_RELOAD;
                    end
                end else if (cnt_in != '0) begin
                    bypass  = 1'b1;
                    cnt_out = cnt_in - CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gen1_scramble_wide.sv
`default_nettype none
// ============================================================================
// Module   : gen1_scramble_wide
// Brief    : Multi-symbol-per-beat PCIe Gen1 scrambler with COM/SKP handling,
//            ordered-set bypass window and a fixed two-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module gen1_scramble_wide
    import pcie_phy_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int OS_LEN    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [5:0]             pipe_width_i,
    input  logic                   data_valid_i,
    input  logic [8*MAX_BYTES-1:0] data_in_i,
    input  logic [MAX_BYTES-1:0]   data_k_in_i,
    input  logic                   scramble_disable_i,
    input  logic                   compliance_i,
    output logic                   data_valid_o,
    output logic [8*MAX_BYTES-1:0] data_out_o,
    output logic [MAX_BYTES-1:0]   data_k_out_o
);

    localparam int CNT_W = $clog2(OS_LEN) + 1;

    typedef struct packed {
        logic [15:0]      lfsr;
        logic [CNT_W-1:0] cnt;
        logic             com_pend;
    } scr_state_t;

    scr_state_t                  r_state;
    scr_state_t                  w_state_next;
    sym_stage_t [MAX_BYTES-1:0]  r_s1;
    sym_stage_t [MAX_BYTES-1:0]  w_s1_next;
    logic                        r_s1_valid;
    logic [8*MAX_BYTES-1:0]      r_s2_data;
    logic [8*MAX_BYTES-1:0]      w_s2_data_next;
    logic [MAX_BYTES-1:0]        r_s2_k;
    logic [MAX_BYTES-1:0]        w_s2_k_next;
    logic                        r_s2_valid;

    logic [15:0]                 w_lfsr_chain [MAX_BYTES+1];
    logic [CNT_W-1:0]            w_cnt_chain  [MAX_BYTES+1];
    logic                        w_pend_chain [MAX_BYTES+1];
    logic [7:0]                  w_key        [MAX_BYTES];
    logic [MAX_BYTES-1:0]        w_bypass;
    logic [MAX_BYTES-1:0]        w_active;
    logic [3:0]                  w_nbytes;
    logic                        w_unused_width_lsbs;

    // A 64-bit width wraps to 0 on the 6-bit width port, so 0 means 8 bytes.
    assign w_nbytes            = (pipe_width_i == 6'd0) ? 4'd8 : {1'b0, pipe_width_i[5:3]};
    assign w_unused_width_lsbs = ^pipe_width_i[2:0];

    assign w_lfsr_chain[0] = r_state.lfsr;
    assign w_cnt_chain[0]  = r_state.cnt;
    assign w_pend_chain[0] = r_state.com_pend;

    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_byte
        assign w_active[gi] = (4'(gi) < w_nbytes);

        byte_scramble #(
            .OS_LEN (OS_LEN),
            .CNT_W  (CNT_W)
        ) u_byte (
            .active   (w_active[gi]),
            .sym      (data_in_i[8*gi +: 8]),
            .sym_k    (data_k_in_i[gi]),
            .lfsr_in  (w_lfsr_chain[gi]),
            .cnt_in   (w_cnt_chain[gi]),
            .pend_in  (w_pend_chain[gi]),
            .lfsr_out (w_lfsr_chain[gi+1]),
            .cnt_out  (w_cnt_chain[gi+1]),
            .pend_out (w_pend_chain[gi+1]),
            .key      (w_key[gi]),
            .bypass   (w_bypass[gi])
        );
    end

    // Scrambler state update, stage-1 lane decisions and stage-2 XOR result.
    always_comb begin
        w_state_next   = r_state;
        w_s1_next      = '0;
        w_s2_data_next = '0;
        w_s2_k_next    = '0;
        if (data_valid_i) begin
            w_state_next.lfsr     = w_lfsr_chain[MAX_BYTES];
            w_state_next.cnt      = w_cnt_chain[MAX_BYTES];
            w_state_next.com_pend = w_pend_chain[MAX_BYTES];
        end
        for (int i = 0; i < MAX_BYTES; i++) begin
            w_s1_next[i].data     = data_in_i[8*i +: 8];
            w_s1_next[i].k        = data_k_in_i[i];
            w_s1_next[i].key      = w_key[i];
            w_s1_next[i].scramble = w_active[i] && !data_k_in_i[i] && !w_bypass[i]
                                    && !scramble_disable_i && !compliance_i;
            w_s2_data_next[8*i +: 8] = r_s1[i].data ^ (r_s1[i].scramble ? r_s1[i].key : 8'h00);
            w_s2_k_next[i]           = r_s1[i].k;
        end
    end

    // State and both pipeline stages; reset reseeds and flushes everything.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state.lfsr     <= LFSR_SEED;
            r_state.cnt      <= '0;
            r_state.com_pend <= 1'b0;
            r_s1             <= '0;
            r_s1_valid       <= 1'b0;
            r_s2_data        <= '0;
            r_s2_k           <= '0;
            r_s2_valid       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s1       <= w_s1_next;
            r_s1_valid <= data_valid_i;
            r_s2_data  <= w_s2_data_next;
            r_s2_k     <= w_s2_k_next;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign data_valid_o = r_s2_valid;
    assign data_out_o   = r_s2_data;
    assign data_k_out_o = r_s2_k;

endmodule
`default_nettype wire

// File: tb/tb_gen1_scramble_wide.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen1_scramble_wide
// Brief    : Self-checking bench for gen1_scramble_wide (MAX_BYTES=4) with a
//            symbol-serial reference scrambler and a per-edge expectation map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen1_scramble_wide;

    localparam int         MB    = 4;
    localparam int         OSL   = 16;
    localparam int         DEPTH = 4096;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_PAD = 8'hF7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    pipe_width = 6'd32;
    logic          din_valid = 1'b0;
    logic [31:0]   din = '0;
    logic [3:0]    din_k = '0;
    logic          scr_dis = 1'b0;
    logic          compl = 1'b0;
    logic          dout_valid;
    logic [31:0]   dout;
    logic [3:0]    dout_k;

    always #5 clk = ~clk;

    gen1_scramble_wide #(
        .MAX_BYTES (MB),
        .OS_LEN    (OSL)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .pipe_width_i       (pipe_width),
        .data_valid_i       (din_valid),
        .data_in_i          (din),
        .data_k_in_i        (din_k),
        .scramble_disable_i (scr_dis),
        .compliance_i       (compl),
        .data_valid_o       (dout_valid),
        .data_out_o         (dout),
        .data_k_out_o       (dout_k)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_n   = 0;
    logic        mon_en   = 1'b0;
    logic        exp_v [DEPTH];
    logic [31:0] exp_d [DEPTH];
    logic [3:0]  exp_k [DEPTH];

    // reference scrambler state (symbol-serial)
    logic [15:0] m_lfsr;
    int          m_rem;
    bit          m_pend;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [7:0] m_keystream();
        logic [7:0] ks;
        for (int j = 0; j < 8; j++) ks[j] = m_lfsr[15-j];
        return ks;
    endfunction

    task automatic m_advance();
        for (int b = 0; b < 8; b++) begin
            m_lfsr = m_lfsr[15] ? ((m_lfsr << 1) ^ 16'h0039) : (m_lfsr << 1);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hFFFF;
        m_rem  = 0;
        m_pend = 0;
    endtask

    // Processes the active symbols of one beat in order, one at a time.
    task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic dis,
                              input logic comp, input int nb, output logic [31:0] o);
        logic [7:0] s;
        logic [7:0] ks;
        bit         in_win;
        bit         is_skp;
        o = d;
        for (int i = 0; i < nb; i++) begin
            s      = d[8*i +: 8];
            ks     = m_keystream();
            is_skp = k[i] && (s == K_SKP);
            if (k[i] && s == K_COM) begin
                m_lfsr = 16'hFFFF;
                m_pend = 1;
                m_rem  = 0;
            end else begin
                in_win = 0;
                if (m_pend) begin
                    m_pend = 0;
                    if (!is_skp) m_rem = OSL - 1;
                end
                if (m_rem > 0) begin
                    in_win = 1;
                    m_rem--;
                end
                if (!k[i] && !dis && !comp && !in_win) o[8*i +: 8] = s ^ ks;
                if (!is_skp) m_advance();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    // Beat sampled at edge E appears after edge E+1.
    task automatic send(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic dis, input logic comp);
        logic [31:0] e;
        e          = d;
        din_valid  = v;
        din        = d;
        din_k      = k;
        scr_dis    = dis;
        compl      = comp;
        if (v) model_beat(d, k, dis, comp, int'(pipe_width) / 8, e);
        tick();
        if (v && edge_n + 1 < DEPTH) begin
            exp_v[edge_n+1] = 1'b1;
            exp_d[edge_n+1] = e;
            exp_k[edge_n+1] = k;
        end
    endtask

    task automatic idle(input logic [5:0] width);
        pipe_width = width;
        send(1'b0, $urandom, 4'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        tick();
        for (int j = edge_n; j < edge_n + 3 && j < DEPTH; j++) exp_v[j] = 1'b0;
        model_reset();
        check_value("rst_valid", 64'(dout_valid), 64'd0);
        check_value("rst_data", 64'(dout), 64'd0);
        check_value("rst_k", 64'(dout_k), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic rand_beat(output logic [31:0] d, output logic [3:0] k);
        int r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                d[8*i +: 8] = K_COM; k[i] = 1'b1;
            end else if (r < 12) begin
                d[8*i +: 8] = K_SKP; k[i] = 1'b1;
            end else if (r < 15) begin
                d[8*i +: 8] = K_PAD; k[i] = 1'b1;
            end else begin
                d[8*i +: 8] = 8'($urandom); k[i] = 1'b0;
            end
        end
    endtask

    // Compare the DUT output against the expectation map every cycle.
    always @(negedge clk) begin
        if (mon_en && edge_n < DEPTH) begin
            check_value("valid_out", 64'(dout_valid), 64'(exp_v[edge_n]));
            if (exp_v[edge_n]) begin
                check_value("data_out", 64'(dout), 64'(exp_d[edge_n]));
                check_value("k_out", 64'(dout_k), 64'(exp_k[edge_n]));
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        logic [5:0]  widths [3];
        widths[0] = 6'd8; widths[1] = 6'd16; widths[2] = 6'd32;
        for (int j = 0; j < DEPTH; j++) begin
            exp_v[j] = 1'b0; exp_d[j] = '0; exp_k[j] = '0;
        end
        model_reset();
        do_reset();
        mon_en = 1'b1;
        do_reset();

        // SKP ordered set then zeros: raw keystream from the seed
        idle(6'd32);
        send(1'b1, {K_SKP, K_SKP, K_SKP, K_COM}, 4'hF, 1'b0, 1'b0);
        send(1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
        exp_d[edge_n+1] = 32'h14C017FF;
        idle(6'd32);

        // width 8: COM, 15 bypassed bytes, then a scrambled zero
        idle(6'd8);
        send(1'b1, {24'($urandom), K_COM}, {3'($urandom), 1'b1}, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            send(1'b1, {24'($urandom), 8'h4A}, {3'($urandom), 1'b0}, 1'b0, 1'b0);
            exp_d[edge_n+1][7:0] = 8'h4A;
        end
        send(1'b1, {24'($urandom), 8'h00}, 4'h0, 1'b0, 1'b0);
        idle(6'd8);

        // width 16: COM in lane 1, window straddles beats, closes mid-beat
        idle(6'd16);
        send(1'b1, {16'h0, K_COM, 8'h33}, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send(1'b1, {16'($urandom), 16'h5A5A}, 4'h0, 1'b0, 1'b0);
            exp_d[edge_n+1][15:0] = 16'h5A5A;
        end
        send(1'b1, {16'h0, 16'h5A5A}, 4'h0, 1'b0, 1'b0);
        exp_d[edge_n+1][7:0] = 8'h5A;
        idle(6'd16);

        // scrambling disabled for 3 beats after a SKP ordered set
        idle(6'd32);
        send(1'b1, {K_SKP, K_SKP, K_SKP, K_COM}, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, $urandom, 4'h0, 1'b1, 1'b0);
        send(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
        send(1'b1, $urandom, 4'h0, 1'b0, 1'b1);

        // valid toggling 1,0,0,1 inside an open window
        send(1'b1, {24'($urandom), K_COM}, 4'h1, 1'b0, 1'b0);
        send(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
        send(1'b0, $urandom, 4'h0, 1'b0, 1'b0);
        send(1'b0, $urandom, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b1, $urandom, 4'h0, 1'b0, 1'b0);

        // reset in the middle of a window with beats in flight
        send(1'b1, {24'($urandom), K_COM}, 4'h1, 1'b0, 1'b0);
        send(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
        send(1'b1, $urandom, 4'h0, 1'b0, 1'b0);
        do_reset();
        send(1'b1, {K_SKP, K_SKP, K_SKP, K_COM}, 4'hF, 1'b0, 1'b0);
        send(1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
        exp_d[edge_n+1] = 32'h14C017FF;

        // randomized traffic, widths changed only on idle cycles
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) idle(widths[$urandom_range(0, 2)]);
            rand_beat(d, k);
            if (pipe_width == 6'd32 && $urandom_range(0, 9) == 0) begin
                d = {K_SKP, K_SKP, K_SKP, K_COM};
                k = 4'hF;
            end
            send(($urandom_range(0, 4) != 0), d, k,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 4; i++) idle(pipe_width);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
